// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit with HI/LO registers; MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        RdSel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_Out
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [CW-1:0]      cnt, cnt_n;
    logic [31:0]        hi_t, lo_t, hi_tn, lo_tn, hi_n, lo_n;
    logic               is_mul, is_div, is_acc, is_sub, sgn;
    logic [63:0]        ma, mb, prod, acc;
    logic signed [32:0] da, db;
    logic [31:0]        quo, rem;

    assign is_mul = (MDUOp == 4'd1) || (MDUOp == 4'd2);
    assign is_div = (MDUOp == 4'd3) || (MDUOp == 4'd4);
    assign is_sub = (MDUOp == 4'd9) || (MDUOp == 4'd10);
    assign sgn    = (MDUOp == 4'd1) || (MDUOp == 4'd3) || (MDUOp == 4'd7) || (MDUOp == 4'd9);
`ifdef MDU_MADD_EN
    assign is_acc = (MDUOp >= 4'd7) && (MDUOp <= 4'd10);
`else
    assign is_acc = 1'b0;
`endif

    // Operands are extended to 64/33 bits so one signed datapath serves both
    // signed and unsigned forms; 33-bit division keeps 0x80000000/-1 well defined.
    assign ma   = sgn ? {{32{A[31]}}, A} : {32'd0, A};
    assign mb   = sgn ? {{32{B[31]}}, B} : {32'd0, B};
    assign prod = ma * mb;
    assign acc  = is_sub ? {HI, LO} - prod : {HI, LO} + prod;
    assign da   = {sgn & A[31], A};
    assign db   = {sgn & B[31], B};
    assign quo  = 32'(da / db);
    assign rem  = 32'(da % db);

    assign state  = (cnt == '0) ? IDLE : BUSY;
    assign Busy   = (state == BUSY);
    assign MD_Out = RdSel ? HI : LO;

    // Next-state: count down and commit in BUSY, accept new ops only in IDLE
    always_comb begin
        cnt_n = cnt;
        hi_n  = HI;
        lo_n  = LO;
        hi_tn = hi_t;
        lo_tn = lo_t;
        if (state == BUSY) begin
            cnt_n = cnt - 1'b1;
            if (cnt == CW'(1)) {hi_n, lo_n} = {hi_t, lo_t};
        end else if (Start) begin
            if (is_mul) begin
                {hi_tn, lo_tn} = prod;
                cnt_n = CW'(MULT_CYCLES);
            end else if (is_acc) begin
                {hi_tn, lo_tn} = acc;
                cnt_n = CW'(MULT_CYCLES);
            end else if (is_div) begin
                {hi_tn, lo_tn} = (B == 32'd0) ? {HI, LO} : {rem, quo};
                cnt_n = CW'(DIV_CYCLES);
            end else if (MDUOp == 4'd5) begin
                hi_n = A;
            end else if (MDUOp == 4'd6) begin
                lo_n = A;
            end
        end
    end

    // State registers with synchronous reset that also aborts in-flight ops
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt  <= '0;
            HI   <= '0;
            LO   <= '0;
            hi_t <= '0;
            lo_t <= '0;
        end else begin
            cnt  <= cnt_n;
            HI   <= hi_n;
            LO   <= lo_n;
            hi_t <= hi_tn;
            lo_t <= lo_tn;
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed self-checking bench for e_mdu
module tb_e_mdu;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  MDUOp = 4'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        RdSel = 1'b0;
    logic        Busy;
    logic [31:0] HI, LO, MD_Out;
    int          errors = 0;
    int          checks = 0;
    int          n;

    e_mdu dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
        .RdSel(RdSel), .Busy(Busy), .HI(HI), .LO(LO), .MD_Out(MD_Out)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op; returns at the negedge of the first cycle after the Start edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Start = 1'b1; MDUOp = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0; MDUOp = 4'd0; A = 32'hDEAD_BEEF; B = 32'hDEAD_BEEF;
    endtask

    task automatic count_busy(output int cyc);
        cyc = 0;
        while (Busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge Clk);
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        check({tag, ".HI"}, HI, hi);
        check({tag, ".LO"}, LO, lo);
        RdSel = 1'b1; #1 check({tag, ".MDhi"}, MD_Out, hi);
        RdSel = 1'b0; #1 check({tag, ".MDlo"}, MD_Out, lo);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        check("rst.busy", 32'(Busy), 32'd0);
        check_hilo("rst", 32'h0, 32'h0);

        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult.hold_hi", HI, 32'h0);
        check("mult.hold_lo", LO, 32'h0);
        count_busy(n);
        check("mult.cycles", 32'(n), 32'd5);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        issue(4'd2, 32'hFFFF_FFFE, 32'd3);
        count_busy(n);
        check("multu.cycles", 32'(n), 32'd5);
        check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div.hold_lo", LO, 32'hFFFF_FFFA);
        count_busy(n);
        check("div.cycles", 32'(n), 32'd10);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(4'd4, 32'd7, 32'd2);
        count_busy(n);
        check("divu.cycles", 32'(n), 32'd10);
        check_hilo("divu", 32'd1, 32'd3);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        check_hilo("divovf", 32'h0, 32'h8000_0000);

        issue(4'd5, 32'h11, 32'h0);
        check("mthi.busy", 32'(Busy), 32'd0);
        issue(4'd6, 32'h22, 32'h0);
        check("mtlo.busy", 32'(Busy), 32'd0);
        check_hilo("mt", 32'h11, 32'h22);
        issue(4'd3, 32'd100, 32'd0);
        count_busy(n);
        check("div0.cycles", 32'(n), 32'd10);
        check_hilo("div0", 32'h11, 32'h22);

        @(negedge Clk);
        Start = 1'b1; MDUOp = 4'd1; A = 32'd3; B = 32'd4;
        @(negedge Clk);
        MDUOp = 4'd6; A = 32'h55;
        @(negedge Clk);
        Start = 1'b0; MDUOp = 4'd0;
        count_busy(n);
        check("ign.cycles", 32'(n), 32'd4);
        check_hilo("ign", 32'h0, 32'd12);

        issue(4'd3, 32'd100, 32'd7);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check("abort.busy", 32'(Busy), 32'd0);
        check_hilo("abort", 32'h0, 32'h0);
        repeat (12) @(negedge Clk);
        check_hilo("abort.late", 32'h0, 32'h0);

        issue(4'd6, 32'h33, 32'h0);
        issue(4'd0, 32'h77, 32'h5);
        check("none.busy", 32'(Busy), 32'd0);
        issue(4'd12, 32'h77, 32'h5);
        check("op12.busy", 32'(Busy), 32'd0);
        check_hilo("none", 32'h0, 32'h33);

        issue(4'd6, 32'hFFFF_FFFF, 32'h0);
        issue(4'd5, 32'h0, 32'h0);
        issue(4'd7, 32'd2, 32'd3);
        count_busy(n);
`ifdef MDU_MADD_EN
        check("madd.cycles", 32'(n), 32'd5);
        check_hilo("madd", 32'd1, 32'd5);
        issue(4'd9, 32'd2, 32'd3);
        count_busy(n);
        check("msub.cycles", 32'(n), 32'd5);
        check_hilo("msub", 32'h0, 32'hFFFF_FFFF);
`else
        check("madd.cycles", 32'(n), 32'd0);
        check_hilo("madd", 32'h0, 32'hFFFF_FFFF);
        issue(4'd9, 32'd2, 32'd3);
        count_busy(n);
        check("msub.cycles", 32'(n), 32'd0);
        check_hilo("msub", 32'h0, 32'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
